// File: rtl/fft_butterfly_if.sv
// fft_butterfly_if: butterfly bus - input pair handshake, twiddle ROM port, result handshake.
// master is the surrounding FFT datapath/ROM, slave is the butterfly.
interface fft_butterfly_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_a_re;
    logic signed [DATA_WIDTH-1:0] in_a_im;
    logic signed [DATA_WIDTH-1:0] in_b_re;
    logic signed [DATA_WIDTH-1:0] in_b_im;
    logic [ADDR_WIDTH-2:0]        in_tw_idx;
    logic [ADDR_WIDTH-1:0]        tw_addr;
    logic signed [DATA_WIDTH-1:0] tw_re;
    logic signed [DATA_WIDTH-1:0] tw_im;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_x0_re;
    logic signed [DATA_WIDTH-1:0] out_x0_im;
    logic signed [DATA_WIDTH-1:0] out_x1_re;
    logic signed [DATA_WIDTH-1:0] out_x1_im;
    logic                         out_ovf;

    modport master (
        output in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_tw_idx, tw_re, tw_im, out_ready,
        input  in_ready, tw_addr, out_valid, out_x0_re, out_x0_im, out_x1_re, out_x1_im, out_ovf
    );

    modport slave (
        input  in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_tw_idx, tw_re, tw_im, out_ready,
        output in_ready, tw_addr, out_valid, out_x0_re, out_x0_im, out_x1_re, out_x1_im, out_ovf
    );
endinterface

// File: rtl/fft_butterfly.sv
// fft_butterfly: 3-stage radix-2 DIT butterfly X0/X1 = A +/- B*W, fed by a 1-cycle registered twiddle ROM.
// Define FFT_BFLY_SCALE_EN to halve each output component (rounded) before saturation.
module fft_butterfly #(
    parameter int DATA_WIDTH = 16,
    parameter int FFT_POINTS = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    fft_butterfly_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int TW = W + 2;
    localparam int SW = W + 3;
    localparam int PW = 2 * W + 1;
    localparam logic signed [PW-1:0] RND  = PW'(1) << (W - 2);
    localparam logic signed [SW-1:0] MAXV = {{(SW - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    typedef logic signed [W-1:0]  dat_t;
    typedef logic signed [TW-1:0] t_t;
    typedef logic signed [SW-1:0] s_t;

    if (FFT_POINTS != (1 << ADDR_WIDTH)) begin : g_bad_cfg
        $error("fft_butterfly: FFT_POINTS must equal 2**ADDR_WIDTH");
    end

    function automatic s_t scl(input s_t s);
`ifdef FFT_BFLY_SCALE_EN
        return (s + s_t'(1)) >>> 1;
`else
        return s;
`endif
    endfunction

    function automatic logic hit(input s_t s);
        return (s > MAXV) || (s < MINV);
    endfunction

    function automatic dat_t sat(input s_t s);
        return (s > MAXV) ? dat_t'(MAXV) : (s < MINV) ? dat_t'(MINV) : dat_t'(s);
    endfunction

    logic                  stall;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] tw_addr_d, tw_addr_q;
    logic                  v1_d, v1_q, v2_d, v2_q, v3_d, v3_q, ovf_d, ovf_q;
    dat_t                  a1_re_d, a1_re_q, a1_im_d, a1_im_q;
    dat_t                  b1_re_d, b1_re_q, b1_im_d, b1_im_q;
    dat_t                  a2_re_d, a2_re_q, a2_im_d, a2_im_q;
    t_t                    t_re_d, t_re_q, t_im_d, t_im_q;
    dat_t                  x0_re_d, x0_re_q, x0_im_d, x0_im_q;
    dat_t                  x1_re_d, x1_re_q, x1_im_d, x1_im_q;
    logic signed [PW-1:0]  p_re, p_im;
    s_t                    s0_re, s0_im, s1_re, s1_im;

    always_comb begin
        stall     = v3_q && !bus.out_ready;
        accept    = bus.in_valid && !stall;
        // Address holds while S1 waits so the ROM keeps presenting that sample's twiddle.
        tw_addr_d = accept ? {1'b0, bus.in_tw_idx} : tw_addr_q;
        v1_d      = stall ? v1_q : accept;
        a1_re_d   = accept ? bus.in_a_re : a1_re_q;
        a1_im_d   = accept ? bus.in_a_im : a1_im_q;
        b1_re_d   = accept ? bus.in_b_re : b1_re_q;
        b1_im_d   = accept ? bus.in_b_im : b1_im_q;
        p_re      = PW'(b1_re_q) * PW'(bus.tw_re) - PW'(b1_im_q) * PW'(bus.tw_im);
        p_im      = PW'(b1_re_q) * PW'(bus.tw_im) + PW'(b1_im_q) * PW'(bus.tw_re);
        v2_d      = stall ? v2_q : v1_q;
        a2_re_d   = stall ? a2_re_q : a1_re_q;
        a2_im_d   = stall ? a2_im_q : a1_im_q;
        t_re_d    = stall ? t_re_q : t_t'((p_re + RND) >>> (W - 1));
        t_im_d    = stall ? t_im_q : t_t'((p_im + RND) >>> (W - 1));
        s0_re     = scl(s_t'(a2_re_q) + s_t'(t_re_q));
        s0_im     = scl(s_t'(a2_im_q) + s_t'(t_im_q));
        s1_re     = scl(s_t'(a2_re_q) - s_t'(t_re_q));
        s1_im     = scl(s_t'(a2_im_q) - s_t'(t_im_q));
        v3_d      = stall ? v3_q : v2_q;
        x0_re_d   = stall ? x0_re_q : sat(s0_re);
        x0_im_d   = stall ? x0_im_q : sat(s0_im);
        x1_re_d   = stall ? x1_re_q : sat(s1_re);
        x1_im_d   = stall ? x1_im_q : sat(s1_im);
        ovf_d     = stall ? ovf_q : (hit(s0_re) | hit(s0_im) | hit(s1_re) | hit(s1_im));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tw_addr_q <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            a1_re_q   <= '0;
            a1_im_q   <= '0;
            b1_re_q   <= '0;
            b1_im_q   <= '0;
            a2_re_q   <= '0;
            a2_im_q   <= '0;
            t_re_q    <= '0;
            t_im_q    <= '0;
            x0_re_q   <= '0;
            x0_im_q   <= '0;
            x1_re_q   <= '0;
            x1_im_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            tw_addr_q <= tw_addr_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            a1_re_q   <= a1_re_d;
            a1_im_q   <= a1_im_d;
            b1_re_q   <= b1_re_d;
            b1_im_q   <= b1_im_d;
            a2_re_q   <= a2_re_d;
            a2_im_q   <= a2_im_d;
            t_re_q    <= t_re_d;
            t_im_q    <= t_im_d;
            x0_re_q   <= x0_re_d;
            x0_im_q   <= x0_im_d;
            x1_re_q   <= x1_re_d;
            x1_im_q   <= x1_im_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_ready  = !stall;
    assign bus.tw_addr   = tw_addr_d;
    assign bus.out_valid = v3_q;
    assign bus.out_x0_re = x0_re_q;
    assign bus.out_x0_im = x0_im_q;
    assign bus.out_x1_re = x1_re_q;
    assign bus.out_x1_im = x1_im_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_fft_butterfly.sv
// tb_fft_butterfly: directed and randomized checks of fft_butterfly against a twiddle ROM model.
// Expected results come from hand-computed constants and an integer reference model.
module tb_fft_butterfly;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   nrx = 0;
    int   rx0;
    logic [64:0] q[$];
    logic [64:0] res;
    logic [64:0] held_v;
    logic        held;
    logic        acc;
    logic [5:0]  last_idx;
    logic signed [15:0] rom_re[32];
    logic signed [15:0] rom_im[32];

`ifdef FFT_BFLY_SCALE_EN
    localparam logic [64:0] E1 = {16'h0C00, 16'h0000, 16'h0400, 16'h0000, 1'b0};
    localparam logic [64:0] E2 = {16'h0000, 16'hFE00, 16'h0000, 16'h0200, 1'b0};
    localparam logic [64:0] E3 = {16'h7000, 16'h0000, 16'h0001, 16'h0000, 1'b0};
`else
    localparam logic [64:0] E1 = {16'h1800, 16'h0000, 16'h0800, 16'h0000, 1'b0};
    localparam logic [64:0] E2 = {16'h0000, 16'hFC00, 16'h0000, 16'h0400, 1'b0};
    localparam logic [64:0] E3 = {16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 1'b1};
`endif

    fft_butterfly_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bus ();

    fft_butterfly #(.DATA_WIDTH(16), .FFT_POINTS(64), .ADDR_WIDTH(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign res = {bus.out_x0_re, bus.out_x0_im, bus.out_x1_re, bus.out_x1_im, bus.out_ovf};

    always @(posedge clk) begin
        bus.tw_re <= rom_re[bus.tw_addr[4:0]];
        bus.tw_im <= rom_im[bus.tw_addr[4:0]];
    end

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic signed [15:0] twq(input real x);
        real y;
        y = x * 32768.0;
        if (y > 32767.0) y = 32767.0;
        return 16'($rtoi(y < 0.0 ? y - 0.5 : y + 0.5));
    endfunction

    function automatic logic [64:0] model(input logic signed [15:0] ar, ai, br, bi, wr, wi);
        longint t_re, t_im;
        longint s[4];
        logic [15:0] x[4];
        logic ov;
        ov   = 1'b0;
        t_re = (longint'(br) * longint'(wr) - longint'(bi) * longint'(wi) + 64'sd16384) >>> 15;
        t_im = (longint'(br) * longint'(wi) + longint'(bi) * longint'(wr) + 64'sd16384) >>> 15;
        s[0] = longint'(ar) + t_re;
        s[1] = longint'(ai) + t_im;
        s[2] = longint'(ar) - t_re;
        s[3] = longint'(ai) - t_im;
        for (int i = 0; i < 4; i++) begin
`ifdef FFT_BFLY_SCALE_EN
            s[i] = (s[i] + 1) >>> 1;
`endif
            if (s[i] > 32767) begin
                s[i] = 32767;
                ov = 1'b1;
            end else if (s[i] < -32768) begin
                s[i] = -32768;
                ov = 1'b1;
            end
            x[i] = 16'(s[i]);
        end
        return {x[0], x[1], x[2], x[3], ov};
    endfunction

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            last_idx = '0;
            held = 1'b0;
        end else begin
            acc = bus.in_valid && bus.in_ready;
            chk("in_ready", 65'(bus.in_ready), 65'(!(bus.out_valid && !bus.out_ready)));
            chk("tw_addr", 65'(bus.tw_addr), 65'(acc ? {1'b0, bus.in_tw_idx} : last_idx));
            if (held) chk("hold", res, held_v);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) chk("dup", 65'(1), 65'(0));
                else begin
                    chk("result", res, q.pop_front());
                    nrx++;
                end
            end
            held   = bus.out_valid && !bus.out_ready;
            held_v = res;
            if (acc) begin
                q.push_back(model(bus.in_a_re, bus.in_a_im, bus.in_b_re, bus.in_b_im,
                                  rom_re[bus.in_tw_idx], rom_im[bus.in_tw_idx]));
                last_idx = {1'b0, bus.in_tw_idx};
            end
        end
    end

    task automatic new_pair();
        bus.in_a_re   = 16'($urandom);
        bus.in_a_im   = 16'($urandom);
        bus.in_b_re   = 16'($urandom);
        bus.in_b_im   = 16'($urandom);
        bus.in_tw_idx = 5'($urandom);
    endtask

    task automatic run_one(input logic [15:0] ar, ai, br, bi, input logic [4:0] k, input logic [64:0] exp);
        bus.out_ready = 1'b1;
        bus.in_a_re   = ar;
        bus.in_a_im   = ai;
        bus.in_b_re   = br;
        bus.in_b_im   = bi;
        bus.in_tw_idx = k;
        bus.in_valid  = 1'b1;
        #1;
        chk("one_ready", 65'(bus.in_ready), 65'(1));
        chk("one_addr", 65'(bus.tw_addr), 65'({1'b0, k}));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("lat1", 65'(bus.out_valid), 65'(0));
        @(posedge clk); #1;
        chk("lat2", 65'(bus.out_valid), 65'(0));
        @(posedge clk); #1;
        chk("lat3", 65'(bus.out_valid), 65'(1));
        chk("one_res", res, exp);
    endtask

    task automatic drive(input int n, input bit rnd);
        int  sent = 0;
        int  cyc = 0;
        bit  took;
        bus.in_valid = 1'b0;
        while (sent < n && cyc < 30 * n + 100) begin
            if (!bus.in_valid) begin
                bus.in_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
                if (bus.in_valid) new_pair();
            end
            bus.out_ready = rnd ? ($urandom_range(3) != 0) : !(cyc >= 3 && cyc < 7);
            @(negedge clk);
            if (!rnd) chk("stall_ready", 65'(bus.in_ready), 65'(!(cyc >= 3 && cyc < 7)));
            took = bus.in_valid && bus.in_ready;
            if (took) sent++;
            @(posedge clk); #1;
            if (took) bus.in_valid = 1'b0;
            cyc++;
        end
        chk("sent", 65'(sent), 65'(n));
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        #1;
        chk("drain", 65'(q.size()), 65'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 32; k++) begin
            rom_re[k] = twq($cos(2.0 * 3.14159265358979 * k / 64.0));
            rom_im[k] = twq(-$sin(2.0 * 3.14159265358979 * k / 64.0));
        end
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_a_re   = '0;
        bus.in_a_im   = '0;
        bus.in_b_re   = '0;
        bus.in_b_im   = '0;
        bus.in_tw_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 65'(bus.out_valid), 65'(0));
        chk("rst_data", res, 65'(0));
        chk("rst_addr", 65'(bus.tw_addr), 65'(0));
        chk("rst_ready", 65'(bus.in_ready), 65'(1));
        rst_n = 1'b1;

        run_one(16'h1000, 16'h0000, 16'h0800, 16'h0000, 5'd0, E1);
        run_one(16'h0000, 16'h0000, 16'h0400, 16'h0000, 5'd16, E2);
        run_one(16'h7000, 16'h0000, 16'h7000, 16'h0000, 5'd0, E3);
        drain();

        rx0 = nrx;
        drive(8, 1'b0);
        drain();
        chk("stream_count", 65'(nrx - rx0), 65'(8));

        for (int i = 0; i < 3; i++) begin
            new_pair();
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", 65'(bus.out_valid), 65'(0));
        chk("midrst_data", res, 65'(0));
        chk("midrst_addr", 65'(bus.tw_addr), 65'(0));
        rst_n = 1'b1;
        chk("midrst_ready", 65'(bus.in_ready), 65'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stale", 65'(bus.out_valid), 65'(0));
        end
        run_one(16'h0000, 16'h0000, 16'h0400, 16'h0000, 5'd16, E2);
        drain();

        rx0 = nrx;
        drive(1000, 1'b1);
        drain();
        chk("random_count", 65'(nrx - rx0), 65'(1000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_butterfly.md
Name: fft_butterfly

Overview:
- Pipelined radix-2 DIT butterfly: the consumer of the twiddle factor ROM.
- Accepts a complex pair (A, B) plus a twiddle index, and drives the ROM address on the accept cycle.
- Aligns the operands with the ROM's 1-cycle registered read, then computes X0 = A + B*W and X1 = A - B*W in Q1.(DATA_WIDTH-1).
- Sits between the FFT sample memory read port and its write-back port.

Parameters:
- DATA_WIDTH, 16, width of each real/imag component and twiddle component (Q1.DATA_WIDTH-1).
- FFT_POINTS, 64, FFT size; the twiddle table holds FFT_POINTS/2 entries.
- ADDR_WIDTH, 6, log2(FFT_POINTS); width of the twiddle ROM address.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input pair valid
- in_ready  out  1  block can accept this cycle
- in_a_re, in_a_im  in  DATA_WIDTH each  operand A, signed
- in_b_re, in_b_im  in  DATA_WIDTH each  operand B, signed
- in_tw_idx  in  ADDR_WIDTH-1  twiddle index k, range 0..FFT_POINTS/2-1
- tw_addr  out  ADDR_WIDTH  twiddle ROM address, zero-extended from the index
- tw_re, tw_im  in  DATA_WIDTH each  twiddle ROM data, valid 1 cycle after tw_addr
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_x0_re, out_x0_im, out_x1_re, out_x1_im  out  DATA_WIDTH each  results, signed
- out_ovf  out  1  saturation occurred on any component of the current result

Behaviour:
- Accept condition: accept = in_valid && in_ready. The transfer happens at the rising edge where accept is high.
- Stall condition: stall = out_valid && !out_ready. in_ready = !stall, combinational.
- Pipeline: stages S1 (ROM read / operand hold), S2 (multiply), S3 (add/sub/output), each with its own valid bit.
  - All stage registers and valid bits hold while stall=1.
  - When not stalled, data advances one stage per cycle.
  - Bubbles propagate as valid=0.
- Latency: out_valid rises exactly 3 cycles after the accept edge when there is no stall. Throughput is 1 pair per cycle.
- Twiddle address:
  - tw_addr = accept ? {0, in_tw_idx} : tw_addr_q.
  - tw_addr_q is loaded with in_tw_idx on accept.
  - The address is therefore stable during a stall, so the ROM output for the sample held in S1 does not change.
  - S1 operands are registered on accept; tw_re/tw_im are sampled together with them into S2.
- Multiply (S2), on full-precision products:
  - T_re = br*wr - bi*wi
  - T_im = br*wi + bi*wr
  - Round: add 2^(DATA_WIDTH-2), then arithmetic shift right by DATA_WIDTH-1.
  - Keep T in DATA_WIDTH+2 bits; no saturation here, so W = 0x8000 (-1.0) is exact.
- Add/sub (S3):
  - S0 = A + T and S1 = A - T, computed in DATA_WIDTH+3 bits, sign-extended.
  - Saturate each component to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - out_ovf = OR of the four per-component saturation events. It is per result, not sticky.
- Reset: when rst_n=0 at an edge, all valid bits, all out_* data, out_ovf and tw_addr_q clear to 0.
  - Reset mid-operation discards in-flight samples; none emerge after reset.
  - in_ready=1 in the cycle after reset is released.
- Simultaneous events: a stall with in_valid=1 accepts nothing and the input must be held by the source. Releasing out_ready with a full pipeline resumes with no loss or duplication.
- Outputs are registered; data outputs are don't-care when out_valid=0 but do not change while stalled.

Optional Feature:
- Macro: FFT_BFLY_SCALE_EN
- Defined: per-stage divide-by-2 before saturation, applied per component as (S + 1) >>> 1. This prevents growth across log2(N) stages. out_ovf can then fire only for |A| + |T| >= 2.0.
- Undefined: no scaling; saturate only.
- Latency is unchanged in both cases.

Test Plan:
- W=(0x7FFF,0), A=(0x1000,0), B=(0x0800,0), k=0 -> tw_addr=0 on the accept cycle; 3 cycles later X0=(0x1800,0), X1=(0x0800,0), ovf=0. With FFT_BFLY_SCALE_EN: X0=(0x0C00,0), X1=(0x0400,0).
- W=(0x0000,0x8000), A=(0,0), B=(0x0400,0), k=16 -> tw_addr=16; X0=(0x0000,0xFC00), X1=(0x0000,0x0400).
- W=(0x7FFF,0), A=(0x7000,0), B=(0x7000,0) -> T_re=0x6FFF; X0_re=0x7FFF with ovf=1, X1_re=0x0001. With FFT_BFLY_SCALE_EN: X0_re=0x7000, ovf=0, X1_re=0x0001.
- Stream 8 back-to-back pairs, drop out_ready for 4 cycles mid-stream -> in_ready=0 exactly while out_valid && !out_ready; tw_addr is held; all 8 results arrive in order, none lost or duplicated; the held result is stable during the stall.
- Stream 3 pairs, assert rst_n=0 for 1 cycle while all are in flight -> out_valid=0 and outputs 0 from the next edge; no stale result appears afterwards; a fresh pair gives a correct result 3 cycles after accept.
- Random A, B, k against a golden model using the ROM contents, with random in_valid/out_ready gaps -> bit-exact match including out_ovf, 1000 samples.
